// File: rtl/xnor_compare_sched_if.sv
// Requester/result bundle for xnor_compare_sched. The master side is the operand
// producer (and result consumer); the slave side is the sequencer itself.
interface xnor_compare_sched_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic             req0;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic             req1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             gnt0;
  logic             gnt1;
  logic             busy;
  logic             done;
  logic             done_id;
  logic             eq;
  logic [CW-1:0]    match_cnt;
  logic [WIDTH-1:0] xnor_bits;

  modport master (
    output req0, a0, b0, req1, a1, b1,
    input  gnt0, gnt1, busy, done, done_id, eq, match_cnt, xnor_bits
  );

  modport slave (
    input  req0, a0, b0, req1, a1, b1,
    output gnt0, gnt1, busy, done, done_id, eq, match_cnt, xnor_bits
  );
endinterface

// File: rtl/xnor_compare_sched.sv
// Round-robin sequencer sharing one bit-serial 5-NAND XNOR cell between two
// requesters; reports equality, match count and the XNOR vector.
module xnor_compare_sched #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  xnor_compare_sched_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] vec;
  logic [WIDTH-1:0] vec_next;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_next;
  logic [CW-1:0]    idx;
  logic             last;
  logic             n1, n2, n3, n4, x;
  logic             take0, take1;

  always_comb begin
    // Classic NAND equality gate: n1..n4 form XOR, the fifth NAND inverts it.
    n1 = ~(a_sh[0] & b_sh[0]);
    n2 = ~(a_sh[0] & n1);
    n3 = ~(b_sh[0] & n1);
    n4 = ~(n2 & n3);
    x  = ~(n4 & n4);
    vec_next = vec >> 1;
    vec_next[WIDTH-1] = x;
    cnt_next = cnt + CW'(x);
    // On a tie the requester that was not served last wins.
    take0 = bus.req0 & (~bus.req1 | last);
    take1 = bus.req1 & ~take0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      a_sh          <= '0;
      b_sh          <= '0;
      vec           <= '0;
      cnt           <= '0;
      idx           <= '0;
      last          <= 1'b1;
      bus.gnt0      <= 1'b0;
      bus.gnt1      <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.done_id   <= 1'b0;
      bus.eq        <= 1'b0;
      bus.match_cnt <= '0;
      bus.xnor_bits <= '0;
    end else begin
      bus.gnt0 <= 1'b0;
      bus.gnt1 <= 1'b0;
      bus.done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (take0 || take1) begin
            a_sh        <= take1 ? bus.a1 : bus.a0;
            b_sh        <= take1 ? bus.b1 : bus.b0;
            vec         <= '0;
            cnt         <= '0;
            idx         <= '0;
            last        <= take1;
            bus.done_id <= take1;
            bus.gnt0    <= take0;
            bus.gnt1    <= take1;
            bus.busy    <= 1'b1;
            state       <= RUN;
          end else begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          vec  <= vec_next;
          cnt  <= cnt_next;
          idx  <= idx + CW'(1);
          if (idx == CW'(WIDTH - 1)) begin
            bus.xnor_bits <= vec_next;
            bus.match_cnt <= cnt_next;
            bus.eq        <= (cnt_next == CW'(WIDTH));
            bus.done      <= 1'b1;
            state         <= DONE;
          end
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_xnor_compare_sched.sv
// Scoreboard bench for xnor_compare_sched: WIDTH=8 and WIDTH=1 instances share
// clock and reset; expected results are queued at issue and checked on done.
module tb_xnor_compare_sched;
  typedef struct {
    logic       id;
    logic       eq;
    int         cnt;
    logic [7:0] bits;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t q8[$];
  exp_t q1[$];
  int   g8[$];
  int   g1[$];
  int   done_c8[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  xnor_compare_sched_if #(.WIDTH(8)) i8 ();
  xnor_compare_sched_if #(.WIDTH(1)) i1 ();

  xnor_compare_sched #(.WIDTH(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(i8.slave));
  xnor_compare_sched #(.WIDTH(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(i1.slave));

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (i8.gnt0 || i8.gnt1) begin
        check("gnt_onehot8", int'(i8.gnt0 & i8.gnt1), 0);
        g8.push_back(cyc);
      end
      if (i8.done) begin
        done_c8.push_back(cyc);
        if (q8.size() == 0) begin
          check("unexpected_done8", 1, 0);
        end else begin
          exp_t e;
          e = q8.pop_front();
          check("done_id8", int'(i8.done_id), int'(e.id));
          check("eq8", int'(i8.eq), int'(e.eq));
          check("match_cnt8", int'(i8.match_cnt), e.cnt);
          check("xnor_bits8", int'(i8.xnor_bits), int'(e.bits));
          check("latency8", (g8.size() > 0) ? cyc - g8.pop_front() : -1, 8);
        end
      end
    end
  end

  // Monitor for the 1-bit instance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (i1.gnt0 || i1.gnt1) begin
        check("gnt_onehot1", int'(i1.gnt0 & i1.gnt1), 0);
        g1.push_back(cyc);
      end
      if (i1.done) begin
        if (q1.size() == 0) begin
          check("unexpected_done1", 1, 0);
        end else begin
          exp_t e;
          e = q1.pop_front();
          check("done_id1", int'(i1.done_id), int'(e.id));
          check("eq1", int'(i1.eq), int'(e.eq));
          check("match_cnt1", int'(i1.match_cnt), e.cnt);
          check("xnor_bits1", int'(i1.xnor_bits), int'(e.bits[0]));
          check("latency1", (g1.size() > 0) ? cyc - g1.pop_front() : -1, 1);
        end
      end
    end
  end

  task automatic issue8(input bit id, input logic [7:0] a, input logic [7:0] b,
                        input bit push, input logic e_eq, input int e_cnt,
                        input logic [7:0] e_bits);
    bit got;
    if (push) q8.push_back('{id, e_eq, e_cnt, e_bits});
    if (id) begin
      i8.a1 = a; i8.b1 = b; i8.req1 = 1'b1;
    end else begin
      i8.a0 = a; i8.b0 = b; i8.req0 = 1'b1;
    end
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (id ? i8.gnt1 : i8.gnt0) got = 1'b1;
    end
    i8.req0 = 1'b0;
    i8.req1 = 1'b0;
    check("gnt_timeout8", int'(got), 1);
  endtask

  task automatic issue1(input bit id, input logic a, input logic b,
                        input logic e_eq);
    bit got;
    q1.push_back('{id, e_eq, int'(e_eq), {7'b0, e_eq}});
    if (id) begin
      i1.a1 = a; i1.b1 = b; i1.req1 = 1'b1;
    end else begin
      i1.a0 = a; i1.b0 = b; i1.req0 = 1'b1;
    end
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (id ? i1.gnt1 : i1.gnt0) got = 1'b1;
    end
    i1.req0 = 1'b0;
    i1.req1 = 1'b0;
    check("gnt_timeout1", int'(got), 1);
  endtask

  task automatic wait_idle8();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!i8.busy) break;
    end
  endtask

  task automatic wait_idle1();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!i1.busy) break;
    end
  endtask

  initial begin
    int  n0;
    bit  s0, s1;
    i8.req0 = 1'b0; i8.req1 = 1'b0;
    i8.a0 = '0; i8.b0 = '0; i8.a1 = '0; i8.b1 = '0;
    i1.req0 = 1'b0; i1.req1 = 1'b0;
    i1.a0 = '0; i1.b0 = '0; i1.a1 = '0; i1.b1 = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_state8", int'({i8.gnt0, i8.gnt1, i8.busy, i8.done, i8.done_id,
                                i8.eq, i8.match_cnt, i8.xnor_bits}), 0);
    check("reset_state1", int'({i1.gnt0, i1.gnt1, i1.busy, i1.done, i1.done_id,
                                i1.eq, i1.match_cnt, i1.xnor_bits}), 0);

    // Simultaneous requests right after reset: req0 wins, req1 goes back-to-back.
    q8.push_back('{1'b0, 1'b1, 8, 8'hFF});
    q8.push_back('{1'b1, 1'b0, 7, 8'h7F});
    n0 = done_c8.size();
    i8.a0 = 8'h55; i8.b0 = 8'h55; i8.a1 = 8'h81; i8.b1 = 8'h01;
    i8.req0 = 1'b1; i8.req1 = 1'b1;
    s0 = 1'b0; s1 = 1'b0;
    for (int k = 0; k < 60 && !(s0 && s1); k++) begin
      @(negedge clk);
      if (i8.gnt0) begin
        check("tie_order", int'(s1), 0);
        s0 = 1'b1; i8.req0 = 1'b0;
      end
      if (i8.gnt1) begin
        s1 = 1'b1; i8.req1 = 1'b0;
      end
    end
    i8.req0 = 1'b0; i8.req1 = 1'b0;
    check("tie_both_granted", int'({s0, s1}), 3);
    wait_idle8();
    wait_idle8();
    check("tie_spacing", (done_c8.size() >= n0 + 2) ?
          done_c8[n0 + 1] - done_c8[n0] : -1, 9);

    issue8(1'b0, 8'hA5, 8'hA5, 1'b1, 1'b1, 8, 8'hFF);
    wait_idle8();
    issue8(1'b1, 8'h0F, 8'hF0, 1'b1, 1'b0, 0, 8'h00);
    wait_idle8();
    issue8(1'b0, 8'h3C, 8'h35, 1'b1, 1'b0, 6, 8'hF6);
    wait_idle8();

    // Abort mid-operation: no result may ever appear for this capture.
    issue8(1'b0, 8'h12, 8'h34, 1'b0, 1'b0, 0, 8'h00);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("abort_outputs8", int'({i8.gnt0, i8.gnt1, i8.busy, i8.done, i8.done_id,
                                     i8.eq, i8.match_cnt, i8.xnor_bits}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    g8.delete();
    repeat (15) @(negedge clk);
    check("abort_idle8", int'(i8.busy), 0);

    issue8(1'b0, 8'hFF, 8'hFF, 1'b1, 1'b1, 8, 8'hFF);
    wait_idle8();

    issue1(1'b0, 1'b0, 1'b0, 1'b1);
    wait_idle1();
    issue1(1'b1, 1'b0, 1'b1, 1'b0);
    wait_idle1();
    issue1(1'b0, 1'b1, 1'b0, 1'b0);
    wait_idle1();
    issue1(1'b1, 1'b1, 1'b1, 1'b1);
    wait_idle1();

    for (int k = 0; k < 50 && (q8.size() != 0 || q1.size() != 0); k++)
      @(negedge clk);
    check("drained8", q8.size(), 0);
    check("drained1", q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
